// File: rtl/datagram_receiver.sv
// datagram_receiver: deserializes one broadcast frame (payload then check
// field, both LSB first), verifies the seeded XOR checksum, holds good frames
// in a shadow register and commits them to the display output only on
// commit_tick so a scene never changes mid-raster.
// Optional feature macro RX_TIMEOUT_EN: blank the output after TIMEOUT_TICKS
// commit ticks pass without a successful commit.
module datagram_receiver #(
  parameter int unsigned       MESSAGE_SIZE  = 16,
  parameter int unsigned       CHK_W         = 8,
  parameter logic [CHK_W-1:0]  CHK_SEED      = 8'hA5,
  parameter int unsigned       ERR_CNT_W     = 8,
  parameter int unsigned       TIMEOUT_TICKS = 60
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ser_frame,
  input  logic                    ser_strobe,
  input  logic                    ser_data,
  input  logic                    commit_tick,
  output logic [MESSAGE_SIZE-1:0] datagram,
  output logic                    datagram_valid,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int unsigned TOT  = MESSAGE_SIZE + CHK_W;
  localparam int unsigned BC_W = $clog2(TOT + 1);
  localparam int unsigned CP_W = (CHK_W > 1) ? $clog2(CHK_W) : 1;

  typedef enum logic [1:0] {IDLE, RECV, CHECK, WAIT_END} state_t;

  state_t                  state, state_next;
  logic                    frame_prev;
  logic [BC_W-1:0]         bit_cnt;
  logic [CP_W-1:0]         chk_pos;
  logic [CHK_W-1:0]        chk;
  logic [TOT-1:0]          shift_reg;
  logic [MESSAGE_SIZE-1:0] shadow;
  logic                    pending;

  logic start, shift, short_err, check_ok, check_bad;
  logic check_match;

  assign check_match = (shift_reg[TOT-1:MESSAGE_SIZE] == chk);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift      = 1'b0;
    short_err  = 1'b0;
    check_ok   = 1'b0;
    check_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ser_frame && !frame_prev) begin
          start      = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        if (!ser_frame) begin
          short_err  = 1'b1;
          state_next = IDLE;
        end else if (ser_strobe) begin
          shift = 1'b1;
          if (bit_cnt == BC_W'(TOT - 1)) state_next = CHECK;
        end
      end
      CHECK: begin
        check_ok   = check_match;
        check_bad  = !check_match;
        state_next = WAIT_END;
      end
      WAIT_END: begin
        if (!ser_frame) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit capture and running checksum; payload bit i folds into chk[i % CHK_W]
  always_ff @(posedge clk) begin
    if (!rst) begin
      // Treat the envelope as already high so a frame in progress at
      // reset release is not mistaken for a new one.
      frame_prev <= 1'b1;
      bit_cnt    <= '0;
      chk_pos    <= '0;
      chk        <= CHK_SEED;
      shift_reg  <= '0;
    end else begin
      frame_prev <= ser_frame;
      if (start) begin
        bit_cnt <= '0;
        chk_pos <= '0;
        chk     <= CHK_SEED;
      end else if (shift) begin
        shift_reg <= {ser_data, shift_reg[TOT-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
        if (bit_cnt < BC_W'(MESSAGE_SIZE)) begin
          chk[chk_pos] <= chk[chk_pos] ^ ser_data;
          if (chk_pos == CP_W'(CHK_W - 1)) chk_pos <= '0;
          else                             chk_pos <= chk_pos + 1'b1;
        end
      end
    end
  end

  // Result pulses and saturating error counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_ok  <= check_ok;
      frame_err <= short_err | check_bad;
      if ((short_err || check_bad) && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] idle_ticks;
`endif

  // Shadow capture and tick-aligned commit; a new good frame is written after
  // the commit so a same-cycle success stays pending for the next tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow         <= '0;
      pending        <= 1'b0;
      datagram       <= '0;
      datagram_valid <= 1'b0;
`ifdef RX_TIMEOUT_EN
      idle_ticks     <= '0;
`endif
    end else begin
      if (commit_tick) begin
        if (pending) begin
          datagram       <= shadow;
          datagram_valid <= 1'b1;
          pending        <= 1'b0;
`ifdef RX_TIMEOUT_EN
          idle_ticks     <= '0;
`endif
        end
`ifdef RX_TIMEOUT_EN
        else if (idle_ticks != TO_W'(TIMEOUT_TICKS)) begin
          idle_ticks <= idle_ticks + 1'b1;
          if (idle_ticks == TO_W'(TIMEOUT_TICKS - 1)) begin
            datagram       <= '0;
            datagram_valid <= 1'b0;
          end
        end
`endif
      end
      if (check_ok) begin
        shadow  <= shift_reg[MESSAGE_SIZE-1:0];
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_datagram_receiver.sv
// Scoreboard bench for datagram_receiver (MESSAGE_SIZE=16, CHK_W=8, seed A5).
// Build with +define+RX_TIMEOUT_EN to also exercise output blanking.
module tb_datagram_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ser_frame = 1'b0;
  logic        ser_strobe = 1'b0;
  logic        ser_data = 1'b0;
  logic        commit_tick = 1'b0;
  logic [15:0] datagram;
  logic        datagram_valid;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_count;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   exp_q[$];          // 1 = good frame expected, 0 = error expected
  logic [7:0] exp_err = '0;

  datagram_receiver #(
    .MESSAGE_SIZE (16),
    .CHK_W        (8),
    .CHK_SEED     (8'hA5),
    .ERR_CNT_W    (8),
    .TIMEOUT_TICKS(60)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ser_frame     (ser_frame),
    .ser_strobe    (ser_strobe),
    .ser_data      (ser_data),
    .commit_tick   (commit_tick),
    .datagram      (datagram),
    .datagram_valid(datagram_valid),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_chk(input logic [15:0] p);
    return 8'hA5 ^ p[7:0] ^ p[15:8];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    commit_tick = 1'b1;
    cyc();
    commit_tick = 1'b0;
    cyc();
  endtask

  // Drives one framed transfer and pushes its expected outcome.
  task automatic send_frame(input logic [15:0] pl, input logic [7:0] ck, input int nbits,
                            input int extra, input bit tick_at_check);
    logic [23:0] bits;
    bits = {ck, pl};
    if (nbits < 24 || ck != model_chk(pl)) begin
      exp_q.push_back(1'b0);
      if (exp_err != 8'hFF) exp_err++;
    end else begin
      exp_q.push_back(1'b1);
    end
    ser_frame = 1'b1;
    cyc();
    for (int i = 0; i < nbits; i++) begin
      ser_data   = bits[i];
      ser_strobe = 1'b1;
      cyc();
      ser_strobe = 1'b0;
      if (tick_at_check && i == nbits - 1) commit_tick = 1'b1;
      cyc();
      commit_tick = 1'b0;
    end
    for (int i = 0; i < extra; i++) begin
      ser_data   = 1'($urandom_range(0, 1));
      ser_strobe = 1'b1;
      cyc();
      ser_strobe = 1'b0;
      cyc();
    end
    cyc();
    ser_frame = 1'b0;
    repeat (3) cyc();
  endtask

  // Scoreboard: every result pulse must match the oldest expected outcome
  always @(negedge clk) begin
    logic [1:0] want;
    if (rst && (frame_ok || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_ok, frame_err}, 32'd0);
      end else begin
        want = exp_q.pop_front() ? 2'b10 : 2'b01;
        check("frame_result", {30'd0, frame_ok, frame_err}, {30'd0, want});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc();
    check("rst_datagram", datagram, 0);
    check("rst_valid", datagram_valid, 0);
    check("rst_ok", frame_ok, 0);
    check("rst_err", frame_err, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b1;
    cyc();

    // Tick with nothing pending leaves the output alone
    tick();
    check("idle_tick_valid", datagram_valid, 0);

    // Good frame is buffered until the tick
    send_frame(16'h1234, 8'h83, 24, 0, 1'b0);
    check("pre_tick_valid", datagram_valid, 0);
    tick();
    check("t1_datagram", datagram, 16'h1234);
    check("t1_valid", datagram_valid, 1);

    // Bad checksum
    send_frame(16'h1234, 8'h84, 24, 0, 1'b0);
    check("t2_err_count", err_count, exp_err);
    tick();
    check("t2_datagram", datagram, 16'h1234);

    // Short frame, then recovery
    send_frame(16'hBEEF, 8'h00, 10, 0, 1'b0);
    check("t3_err_count", err_count, exp_err);
    send_frame(16'hBEEF, model_chk(16'hBEEF), 24, 0, 1'b0);
    tick();
    check("t3_datagram", datagram, 16'hBEEF);

    // Latest pending frame wins; trailing extra bits are discarded silently
    send_frame(16'h0001, 8'hA4, 24, 5, 1'b0);
    send_frame(16'h0002, 8'hA7, 24, 0, 1'b0);
    tick();
    check("t4_datagram", datagram, 16'h0002);
    tick();
    check("t4_hold", datagram, 16'h0002);
    check("t4_err_count", err_count, exp_err);

    // Success coinciding with a tick commits the older shadow only
    send_frame(16'h5555, model_chk(16'h5555), 24, 0, 1'b0);
    send_frame(16'h0F0F, model_chk(16'h0F0F), 24, 0, 1'b1);
    check("same_cycle_old", datagram, 16'h5555);
    tick();
    check("same_cycle_new", datagram, 16'h0F0F);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      if (i % 10 == 0) send_frame(16'(i), ~model_chk(16'(i)), 24, 0, 1'b0);
      else             send_frame(16'(i), 8'h00, 2, 0, 1'b0);
      if (exp_err >= 8'hFD) check("sat_err_count", err_count, exp_err);
    end
    check("sat_final", err_count, 8'hFF);

    // Reset mid-frame clears everything
    ser_frame = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      ser_data = 1'b1; ser_strobe = 1'b1; cyc(); ser_strobe = 1'b0; cyc();
    end
    rst = 1'b0;
    cyc();
    exp_err = '0;
    check("midrst_datagram", datagram, 0);
    check("midrst_valid", datagram_valid, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_pulses", {frame_ok, frame_err}, 0);

    // Envelope already high at reset release must not start a frame
    cyc();
    rst = 1'b1;
    cyc();
    begin
      logic [23:0] bits;
      bits = {model_chk(16'h7777), 16'h7777};
      for (int i = 0; i < 24; i++) begin
        ser_data = bits[i]; ser_strobe = 1'b1; cyc(); ser_strobe = 1'b0; cyc();
      end
    end
    ser_frame = 1'b0;
    repeat (3) cyc();
    tick();
    check("no_start_datagram", datagram, 0);
    check("no_start_valid", datagram_valid, 0);

    send_frame(16'hC3C3, model_chk(16'hC3C3), 24, 0, 1'b0);
    tick();
    check("post_rst_datagram", datagram, 16'hC3C3);

`ifdef RX_TIMEOUT_EN
    repeat (59) tick();
    check("to_59_datagram", datagram, 16'hC3C3);
    check("to_59_valid", datagram_valid, 1);
    tick();
    check("to_60_datagram", datagram, 0);
    check("to_60_valid", datagram_valid, 0);
    send_frame(16'h1234, 8'h83, 24, 0, 1'b0);
    tick();
    check("to_restore_datagram", datagram, 16'h1234);
    check("to_restore_valid", datagram_valid, 1);
`endif

    repeat (5) cyc();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
